// File: rtl/multicycle_controller.sv
// Main control FSM of the RISC-V multicycle processor: sequences each instruction
// through fetch/decode/execute/memory/writeback and decodes ALU and immediate selects.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] SRCB_REG  = 3'b000;
  localparam logic [2:0] SRCB_IMM  = 3'b010;
  localparam logic [2:0] SRCB_FOUR = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_JAL,
    S_BEQ
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Raw Moore outputs before the reset gate on the write enables.
  logic       pc_update;
  logic       branch;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic [1:0] aluop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_IALU:      state_next = S_EXECUTEI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_JAL:      state_next = S_ALUWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = S_FETCH;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = SRCB_REG;
    aluop         = 2'b00;
    case (state_reg)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        alu_src_b    = SRCB_FOUR;
        result_src   = 2'b10;
        pc_update    = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_src_b = SRCB_REG;
        aluop     = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = SRCB_IMM;
        aluop     = 2'b10;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_src_b = SRCB_REG;
        aluop     = 2'b01;
        branch    = 1'b1;
      end
      default: begin
        ir_write_raw = 1'b0;
      end
    endcase
  end

  // While reset is held the state sits in FETCH; gate its enables so nothing commits.
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign ir_write  = rst_n & ir_write_raw;
  assign reg_write = rst_n & reg_write_raw;
  assign mem_write = rst_n & mem_write_raw;

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      2'b00: alu_control = ALU_ADD;
      2'b01: alu_control = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instructions, then a random
// instruction stream with reset pulses, compared against a per-instruction step model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, imm_src;
  logic [2:0] alu_src_b, alu_control;

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IA = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                P_EXR, P_EXI, P_ALUWB, P_JAL, P_BEQ} phase_t;

  // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b, alu_control, imm_src}
  logic [16:0] observed;
  assign observed = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                     alu_src_a, alu_src_b, alu_control, imm_src};

  function automatic int cycles_of(input logic [6:0] o);
    if (o == LW) return 5;
    if (o == SW || o == RT || o == IA || o == JL) return 4;
    if (o == BQ) return 3;
    return 2;
  endfunction

  function automatic phase_t phase_of(input logic [6:0] o, input int step);
    phase_t seq [$];
    seq = '{P_FETCH, P_DECODE};
    if (o == LW) seq = '{P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB};
    if (o == SW) seq = '{P_FETCH, P_DECODE, P_MEMADR, P_MEMWRITE};
    if (o == RT) seq = '{P_FETCH, P_DECODE, P_EXR, P_ALUWB};
    if (o == IA) seq = '{P_FETCH, P_DECODE, P_EXI, P_ALUWB};
    if (o == JL) seq = '{P_FETCH, P_DECODE, P_JAL, P_ALUWB};
    if (o == BQ) seq = '{P_FETCH, P_DECODE, P_BEQ};
    return seq[step];
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic f7, input logic [6:0] o);
    if (f3 == 3'b000) return (f7 && o[5]) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [16:0] expect_vec(input logic [6:0] o, input logic [2:0] f3,
                                             input logic f7, input logic z, input int step);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0;
    logic [1:0] rs = 2'b00, sa = 2'b00;
    logic [2:0] sb = 3'b000, ac = 3'b000;
    case (phase_of(o, step))
      P_FETCH:    begin irw = 1; pcw = 1; rs = 2'b10; sb = 3'b100; end
      P_DECODE:   begin sa = 2'b01; sb = 3'b010; end
      P_MEMADR:   begin sa = 2'b10; sb = 3'b010; end
      P_MEMREAD:  adr = 1;
      P_MEMWB:    begin rs = 2'b01; rw = 1; end
      P_MEMWRITE: begin adr = 1; mw = 1; end
      P_EXR:      begin sa = 2'b10; ac = alu_decode(f3, f7, o); end
      P_EXI:      begin sa = 2'b10; sb = 3'b010; ac = alu_decode(f3, f7, o); end
      P_ALUWB:    rw = 1;
      P_JAL:      begin sa = 2'b01; sb = 3'b100; pcw = 1; end
      P_BEQ:      begin sa = 2'b10; ac = 3'b001; pcw = z; end
      default:    pcw = 0;
    endcase
    return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, imm_of(o)};
  endfunction

  function automatic logic [16:0] reset_vec(input logic [6:0] o);
    return {5'b00000, 2'b10, 2'b00, 3'b100, 3'b000, imm_of(o)};
  endfunction

  task automatic check(input string tag, input logic [16:0] exp);
    checks++;
    assert (observed === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, exp);
    end
    checks++;
    assert (!(alu_src_b inside {3'b001, 3'b011, 3'b101})) else begin
      errors++;
      $error("FAIL %s_srcb observed=%b expected=000/010/100", tag, alu_src_b);
    end
  endtask

  // Holds reset across an edge, checking every write enable stays low, then releases.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1 check({tag, "_async"}, reset_vec(op));
    @(negedge clk) check({tag, "_held"}, reset_vec(op));
    @(negedge clk) check({tag, "_held2"}, reset_vec(op));
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Entered just after an edge with the FSM in FETCH; leaves at the same point.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zsel, input bit allow_reset, input int idx);
    op = o; funct3 = f3; funct7b5 = f7;
    for (int step = 0; step < cycles_of(o); step++) begin
      if (step > 0) begin
        @(posedge clk);
        #2;
      end
      zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      if (allow_reset && step > 0 && $urandom_range(0, 11) == 0) begin
        pulse_reset($sformatf("i%0d_rst_s%0d", idx, step));
        return;
      end
      @(negedge clk);
      check($sformatf("i%0d_op%b_s%0d", idx, o, step), expect_vec(o, f3, f7, zero, step));
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; op = LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    #2 check("reset_start", reset_vec(op));
    @(negedge clk) check("reset_held", reset_vec(op));
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("release_fetch", expect_vec(LW, 3'b010, 1'b0, 1'b0, 0));

    run_instr(LW, 3'b010, 1'b0, -1, 1'b0, 0);
    run_instr(RT, 3'b000, 1'b1, -1, 1'b0, 1);
    run_instr(BQ, 3'b000, 1'b0,  1, 1'b0, 2);
    run_instr(BQ, 3'b000, 1'b0,  0, 1'b0, 3);
    run_instr(SW, 3'b010, 1'b0, -1, 1'b0, 4);
    run_instr(7'b1111111, 3'b000, 1'b0, -1, 1'b0, 5);
    run_instr(IA, 3'b000, 1'b1, -1, 1'b0, 6);
    run_instr(JL, 3'b000, 1'b0, -1, 1'b0, 7);
    run_instr(RT, 3'b111, 1'b0, -1, 1'b0, 8);
    run_instr(IA, 3'b110, 1'b0, -1, 1'b0, 9);

    for (int i = 10; i < 400; i++) begin
      logic [6:0] o;
      case ($urandom_range(0, 6))
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IA;
        4: o = JL;
        5: o = BQ;
        default: o = 7'($urandom);
      endcase
      run_instr(o, 3'($urandom), 1'($urandom_range(0, 1)), -1, 1'b1, i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
